// File: rtl/delay_seq_timer.sv
// -----------------------------------------------------------------------------
// delay_seq_timer
//
// Multi-stage power-up / initialisation delay sequencer. STAGES programmable
// delays run back to back. Each stage raises a sticky done flag and a
// one-cycle strobe when it completes. The block also supports restart (start),
// pause (hold) and optional auto-start out of reset.
//
// Parameters
//   CNT_W      : counter width; per-stage delay values are CNT_W bits wide
//   STAGES     : number of sequential stages (1..16)
//   STG_W      : width of cur_stage; 2**STG_W must be >= STAGES+1
//   DLY_VEC    : per-stage delays, stage k in DLY_VEC[k*CNT_W +: CNT_W]
//                (stage 0 in the least-significant slice); 0 acts as 1
//   AUTO_START : 1 = begin counting straight out of reset, 0 = wait for start
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : synchronous pulse; clears flags and restarts at stage 0
//   hold        : freezes counter and stage while counting
//   stage_done  : sticky per-stage completion flags
//   stage_pulse : one-cycle strobe on completion of each stage
//   cur_stage   : stage currently counting; equals STAGES once complete
//   busy        : high while counting
//   all_done    : completion flag of the last stage
// -----------------------------------------------------------------------------
module delay_seq_timer #(
  parameter int unsigned               CNT_W      = 16,
  parameter int unsigned               STAGES     = 4,
  parameter int unsigned               STG_W      = 4,
  parameter logic [STAGES*CNT_W-1:0]   DLY_VEC    = {16'd12288, 16'd8, 16'd8, 16'd2},
  parameter bit                        AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [STAGES-1:0] stage_done,
  output logic [STAGES-1:0] stage_pulse,
  output logic [STG_W-1:0]  cur_stage,
  output logic              busy,
  output logic              all_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_e;

  localparam state_e RST_STATE = AUTO_START ? S_COUNT : S_IDLE;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STG_W-1:0]    cur_stage_q, cur_stage_d;
  logic [STAGES-1:0]   stage_done_q, stage_done_d;
  logic [STAGES-1:0]   stage_pulse_q, stage_pulse_d;

  // Terminal count of the current stage and a one-hot of the current stage.
  // A programmed delay of 0 shares the terminal count of a delay of 1, so a
  // stage is never skipped.
  logic [CNT_W-1:0]    last_cnt;
  logic [STAGES-1:0]   stage_onehot;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    last_cnt     = '0;
    stage_onehot = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (cur_stage_q == STG_W'(k)) begin
        stage_onehot[k] = 1'b1;
        if (DLY_VEC[k*CNT_W +: CNT_W] != '0) begin
          last_cnt = DLY_VEC[k*CNT_W +: CNT_W] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_stage_d   = cur_stage_q;
    stage_done_d  = stage_done_q;
    stage_pulse_d = '0;

    if (start) begin
      // Restart wins over hold and over a completion on the same edge.
      state_d      = S_COUNT;
      cnt_d        = '0;
      cur_stage_d  = '0;
      stage_done_d = '0;
    end else if ((state_q == S_COUNT) && !hold) begin
      if (cnt_q == last_cnt) begin
        cnt_d         = '0;
        stage_done_d  = stage_done_q | stage_onehot;
        stage_pulse_d = stage_onehot;
        cur_stage_d   = cur_stage_q + STG_W'(1);
        if (cur_stage_q == STG_W'(STAGES - 1)) begin
          state_d = S_DONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RST_STATE;
      cnt_q         <= '0;
      cur_stage_q   <= '0;
      stage_done_q  <= '0;
      stage_pulse_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_stage_q   <= cur_stage_d;
      stage_done_q  <= stage_done_d;
      stage_pulse_q <= stage_pulse_d;
    end
  end

  assign stage_done  = stage_done_q;
  assign stage_pulse = stage_pulse_q;
  assign cur_stage   = cur_stage_q;
  assign busy        = (state_q == S_COUNT);
  assign all_done    = stage_done_q[STAGES-1];

endmodule

// File: tb/tb_delay_seq_timer.sv
// -----------------------------------------------------------------------------
// tb_delay_seq_timer
//
// Three instances of delay_seq_timer, all with STAGES=3:
//   u_a : delays {5,10,3}, auto-start     (fixed timing, hold, restart, random)
//   u_b : delays {5,10,3}, start-driven   (idle behaviour, vector table)
//   u_c : delays {0,1,65535}, auto-start  (zero delay, full-width stage, rst)
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_delay_seq_timer;

  localparam logic [47:0] DLY_AB = {16'd3, 16'd10, 16'd5};
  localparam logic [47:0] DLY_C  = {16'd65535, 16'd1, 16'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, start_a = 1'b0, hold_a = 1'b0;
  logic       rst_b = 1'b1, start_b = 1'b0, hold_b = 1'b0;
  logic       rst_c = 1'b1, start_c = 1'b0, hold_c = 1'b0;
  logic [2:0] done_a, pulse_a, done_b, pulse_b, done_c, pulse_c;
  logic [1:0] stage_a, stage_b, stage_c;
  logic       busy_a, busy_b, busy_c, alld_a, alld_b, alld_c;

  delay_seq_timer #(.CNT_W(16), .STAGES(3), .STG_W(2), .DLY_VEC(DLY_AB), .AUTO_START(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .hold(hold_a),
    .stage_done(done_a), .stage_pulse(pulse_a), .cur_stage(stage_a),
    .busy(busy_a), .all_done(alld_a));

  delay_seq_timer #(.CNT_W(16), .STAGES(3), .STG_W(2), .DLY_VEC(DLY_AB), .AUTO_START(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .hold(hold_b),
    .stage_done(done_b), .stage_pulse(pulse_b), .cur_stage(stage_b),
    .busy(busy_b), .all_done(alld_b));

  delay_seq_timer #(.CNT_W(16), .STAGES(3), .STG_W(2), .DLY_VEC(DLY_C), .AUTO_START(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .hold(hold_c),
    .stage_done(done_c), .stage_pulse(pulse_c), .cur_stage(stage_c),
    .busy(busy_c), .all_done(alld_c));

  int n_tests = 0;
  int n_fail  = 0;

  // Observed / expected output bundle: {pulse, done, stage, busy, all_done}
  function automatic logic [9:0] mk(logic [2:0] p, logic [2:0] d, logic [1:0] s, logic b);
    return {p, d, s, b, d[2]};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {pulse,done,stage,busy,all} = %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs e edges into an un-held run whose three stages
  // complete on edges p0, p1, p2.
  function automatic logic [9:0] exp_run(int e, int p0, int p1, int p2);
    logic [2:0] p, d;
    logic [1:0] s;
    p = '0;
    if (e == p0) p = 3'b001;
    if (e == p1) p = 3'b010;
    if (e == p2) p = 3'b100;
    d = {(e >= p2), (e >= p1), (e >= p0)};
    s = 2'(int'(e >= p0) + int'(e >= p1) + int'(e >= p2));
    return mk(p, d, s, e < p2);
  endfunction

  typedef struct {
    logic       start;
    logic       hold;
    logic [2:0] pulse;
    logic [2:0] done;
    logic [1:0] stage;
    logic       busy;
  } vec_t;

  vec_t tbl [16];

  // High-level reference: elapsed cycles per stage against the effective delay.
  int         m_dly [3] = '{5, 10, 3};
  logic       m_run;
  int         m_k, m_el;
  logic [2:0] m_done, m_pulse;

  initial begin
    // ---------------- vector table for u_b (start-driven) ----------------
    tbl[0]  = '{1'b1, 1'b1, 3'b000, 3'b000, 2'd0, 1'b1};  // start beats hold
    tbl[1]  = '{1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b1};  // held, not counted
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 3'b001, 3'b001, 2'd1, 1'b1};  // 5th counted cycle
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 3'b001, 2'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 3'b000, 3'b001, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};  // restart at edge E
    tbl[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 3'b001, 3'b001, 2'd1, 1'b1};  // E+5
    tbl[15] = '{1'b0, 1'b1, 3'b000, 3'b001, 2'd1, 1'b1};

    tick();
    tick();

    // ---------------- reset state ----------------
    check("reset_a", {pulse_a, done_a, stage_a, busy_a, alld_a}, mk(3'b000, 3'b000, 2'd0, 1'b1));
    check("reset_b", {pulse_b, done_b, stage_b, busy_b, alld_b}, mk(3'b000, 3'b000, 2'd0, 1'b0));

    // ---------------- test 1: free run {5,10,3} ----------------
    rst_a = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("run_edge%0d", e), {pulse_a, done_a, stage_a, busy_a, alld_a},
            exp_run(e, 5, 15, 18));
    end

    // ---------------- test 2: hold 4 cycles during stage 1 ----------------
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      hold_a = (e >= 8 && e <= 11);
      tick();
      check($sformatf("hold_edge%0d", e), {pulse_a, done_a, stage_a, busy_a, alld_a},
            exp_run(e, 5, 19, 22));
    end
    hold_a = 1'b0;

    // ---------------- test 4: start on stage-1 completion edge ----------------
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check($sformatf("pre_restart_edge%0d", e), {pulse_a, done_a, stage_a, busy_a, alld_a},
            exp_run(e, 5, 15, 18));
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_discards_completion", {pulse_a, done_a, stage_a, busy_a, alld_a},
          mk(3'b000, 3'b000, 2'd0, 1'b1));
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("post_restart_edge%0d", e), {pulse_a, done_a, stage_a, busy_a, alld_a},
            exp_run(e, 5, 15, 18));
    end

    // ---------------- test 3: u_b idles, then vector table ----------------
    rst_b = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hold_b = i[0];
      tick();
      check($sformatf("idle_cycle%0d", i), {pulse_b, done_b, stage_b, busy_b, alld_b},
            mk(3'b000, 3'b000, 2'd0, 1'b0));
    end
    for (int i = 0; i < 16; i++) begin
      start_b = tbl[i].start;
      hold_b  = tbl[i].hold;
      tick();
      check($sformatf("vec%0d", i), {pulse_b, done_b, stage_b, busy_b, alld_b},
            mk(tbl[i].pulse, tbl[i].done, tbl[i].stage, tbl[i].busy));
    end
    start_b = 1'b0;
    hold_b  = 1'b0;

    // ---------------- test 5: {0,1,65535} and async reset ----------------
    rst_c = 1'b0;
    tick();
    check("zero_dly_stage0", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b001, 3'b001, 2'd1, 1'b1));
    tick();
    check("one_dly_stage1", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b010, 3'b011, 2'd2, 1'b1));
    repeat (998) tick();
    check("mid_stage2", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b000, 3'b011, 2'd2, 1'b1));
    #2 rst_c = 1'b1;
    #1 check("async_reset", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b000, 3'b000, 2'd0, 1'b1));
    @(negedge clk);
    rst_c = 1'b0;
    tick();
    check("rerun_stage0", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b001, 3'b001, 2'd1, 1'b1));
    tick();
    check("rerun_stage1", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b010, 3'b011, 2'd2, 1'b1));
    // Stage 2 completes on edge 2 + 65535 = 65537.
    repeat (65534) tick();
    check("long_edge65536", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b000, 3'b011, 2'd2, 1'b1));
    tick();
    check("long_edge65537", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b100, 3'b111, 2'd3, 1'b0));
    hold_c = 1'b1;
    tick();
    hold_c = 1'b0;
    check("done_stable", {pulse_c, done_c, stage_c, busy_c, alld_c}, mk(3'b000, 3'b111, 2'd3, 1'b0));

    // ---------------- random start/hold against reference model ----------------
    rst_a = 1'b1;
    tick();
    rst_a   = 1'b0;
    m_run   = 1'b1;
    m_k     = 0;
    m_el    = 0;
    m_done  = '0;
    for (int i = 0; i < 800; i++) begin
      start_a = ($urandom_range(0, 39) == 0);
      hold_a  = ($urandom_range(0, 3) == 0);
      tick();
      m_pulse = '0;
      if (start_a) begin
        m_run  = 1'b1;
        m_k    = 0;
        m_el   = 0;
        m_done = '0;
      end else if (m_run && !hold_a) begin
        m_el++;
        if (m_el >= ((m_dly[m_k] < 1) ? 1 : m_dly[m_k])) begin
          m_done[m_k]  = 1'b1;
          m_pulse[m_k] = 1'b1;
          m_k++;
          m_el = 0;
          if (m_k == 3) m_run = 1'b0;
        end
      end
      check($sformatf("rand_cycle%0d", i), {pulse_a, done_a, stage_a, busy_a, alld_a},
            mk(m_pulse, m_done, 2'(m_k), m_run));
    end
    start_a = 1'b0;
    hold_a  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
